// File: rtl/result_store_pkg.sv
// Shared types and width/constant helpers for the result history store.
package result_store_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LIVE,
    BROWSE
  } state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int off_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Largest positive magnitude representable in a w-bit signed value.
  function automatic logic [63:0] sat_mag(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one bit per cycle, DATA_W cycles per result.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    valid,
  output logic                    busy
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       sh;
  logic [4*BCD_DIGITS-1:0] acc;
  logic [4*BCD_DIGITS-1:0] adj;
  logic [4*BCD_DIGITS-1:0] acc_next;
  logic [CW-1:0]           cnt;

  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {adj[4*BCD_DIGITS-2:0], sh[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      // A new start abandons any conversion in flight, so its result never surfaces.
      if (start) begin
        sh   <= bin;
        acc  <= '0;
        cnt  <= CW'(DATA_W);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= acc_next;
        sh  <= sh << 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
          bcd   <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/result_store.sv
// Circular history of signed results with browse and sign-magnitude output.
// Optional BCD output enabled by defining RESULT_STORE_BCD_EN.
module result_store
  import result_store_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int BCD_DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          store,
  input  logic [DATA_W-1:0]             result_data,
  input  logic                          recall_prev,
  input  logic                          recall_next,
  input  logic                          clear,
  output logic [DATA_W-1:0]             bin_data,
  output logic                          seg_sign,
  output logic                          sat,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic [off_width(DEPTH)-1:0]   offset,
  output logic                          empty,
  output logic                          full
`ifdef RESULT_STORE_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0]       bcd_data,
  output logic                          bcd_valid,
  output logic                          bcd_busy
`endif
);

  localparam int                CNT_W    = cnt_width(DEPTH);
  localparam int                OFF_W    = off_width(DEPTH);
  localparam logic [DATA_W-1:0] SAT_MAG  = DATA_W'(sat_mag(DATA_W));
  localparam logic [DATA_W-1:0] MOST_NEG = ~SAT_MAG;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_n;
  logic [OFF_W-1:0]  wptr, wptr_n, offset_n, sel_idx;
  logic [CNT_W-1:0]  count_n;
  logic              we;
  logic [DATA_W-1:0] sel, mag_n;
  logic              sign_n, sat_n;

  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    count_n  = count;
    offset_n = offset;
    we       = 1'b0;
    if (clear) begin
      state_n  = EMPTY;
      count_n  = '0;
      offset_n = '0;
    end else if (store) begin
      we       = 1'b1;
      wptr_n   = wptr + OFF_W'(1);
      count_n  = (count == CNT_W'(DEPTH)) ? count : count + CNT_W'(1);
      offset_n = '0;
      state_n  = LIVE;
    end else if (recall_prev && state != EMPTY) begin
      if ((CNT_W'(offset) + CNT_W'(1)) < count) begin
        offset_n = offset + OFF_W'(1);
        state_n  = BROWSE;
      end
    end else if (recall_next && state != EMPTY) begin
      if (offset != '0) begin
        offset_n = offset - OFF_W'(1);
        if (offset_n == '0) state_n = LIVE;
      end
    end
  end

  // Outputs are registered from the post-edge view; a store bypasses the array
  // because the written slot is exactly the one selected at offset 0.
  always_comb begin
    sel_idx = wptr_n - OFF_W'(1) - offset_n;
    sel     = we ? result_data : mem[sel_idx];
    mag_n   = '0;
    sign_n  = 1'b0;
    sat_n   = 1'b0;
    if (state_n != EMPTY) begin
      if (sel == MOST_NEG) begin
        mag_n  = SAT_MAG;
        sign_n = 1'b1;
        sat_n  = 1'b1;
      end else begin
        sign_n = sel[DATA_W-1];
        mag_n  = sel[DATA_W-1] ? -sel : sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= result_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      wptr     <= '0;
      count    <= '0;
      offset   <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      bin_data <= '0;
      seg_sign <= 1'b0;
      sat      <= 1'b0;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      count    <= count_n;
      offset   <= offset_n;
      empty    <= (count_n == '0);
      full     <= (count_n == CNT_W'(DEPTH));
      bin_data <= mag_n;
      seg_sign <= sign_n;
      sat      <= sat_n;
    end
  end

`ifdef RESULT_STORE_BCD_EN
  logic upd;

  always_ff @(posedge clk) begin
    if (rst) upd <= 1'b0;
    else     upd <= clear | we | (offset_n != offset);
  end

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(upd),
    .bin  (bin_data),
    .bcd  (bcd_data),
    .valid(bcd_valid),
    .busy (bcd_busy)
  );
`endif

endmodule

// File: doc/result_store.md
Name: result_store

Overview:
Parametrised history store for calculator results. Commits signed two's-complement results into a circular buffer of DEPTH entries, overwriting the oldest entry when full. Lets the user browse older entries one step at a time. Presents the selected entry to the seven-segment path as a registered magnitude plus a sign bit. Sits between the ALU result register and the display driver; it succeeds the single-entry result latch.

Parameters:
DATA_W, 16, width of result_data and bin_data (at least 4).
DEPTH, 8, number of history entries; power of two, at least 2.
BCD_DIGITS, 5, BCD digit count. Used only with RESULT_STORE_BCD_EN; must satisfy 10^BCD_DIGITS > 2^(DATA_W-1).

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
store  input  1  one-cycle pulse; commit result_data as the newest entry
result_data  input  DATA_W  signed two's-complement result
recall_prev  input  1  pulse; step to the next-older entry
recall_next  input  1  pulse; step to the next-newer entry
clear  input  1  pulse; empty the history
bin_data  output  DATA_W  magnitude of the selected entry, zero-extended
seg_sign  output  1  1 when the selected entry is negative
sat  output  1  selected entry is -2^(DATA_W-1); magnitude saturated
count  output  $clog2(DEPTH+1)  number of valid entries
offset  output  $clog2(DEPTH)  browse position; 0 is the newest entry
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, empty=1, write pointer 0, state EMPTY. Memory contents are don't-care.
- States:
  - EMPTY to LIVE on store.
  - LIVE to BROWSE on recall_prev when count > 1.
  - BROWSE to LIVE when offset returns to 0 or on store.
  - Any state to EMPTY on clear or rst.
- Priority per cycle: rst > clear > store > recall_prev > recall_next. Lower-priority pulses in the same cycle are ignored, not queued.
- Store:
  - Write at wptr, then wptr increments modulo DEPTH.
  - count increments, saturating at DEPTH; when full, the oldest entry is overwritten.
  - offset is forced to 0.
- recall_prev: offset increments, clamped at count-1. At the clamp it is a no-op with no wrap.
- recall_next: offset decrements, clamped at 0.
- In EMPTY, recall pulses are ignored.
- Selected entry is mem[(wptr-1-offset) mod DEPTH].
- Output latency: bin_data, seg_sign and sat are registered and valid on the cycle after the edge that changed store contents or offset (1-cycle latency).
- Conversion:
  - seg_sign = msb.
  - bin_data = msb ? -x : x.
  - For x = -2^(DATA_W-1): bin_data = 2^(DATA_W-1)-1, sat=1, seg_sign=1.
  - sat is 0 otherwise.
- EMPTY state: bin_data=0, seg_sign=0, sat=0.
- clear mid-browse: next cycle count=0, offset=0, outputs 0. Stored data is not scrubbed.
- rst takes effect at any point, including mid-conversion.

Optional Feature:
RESULT_STORE_BCD_EN
- Defined:
  - Adds outputs bcd_data [4*BCD_DIGITS-1:0], bcd_valid, bcd_busy.
  - Each update of bin_data starts a sequential double-dabble conversion of bin_data taking DATA_W cycles, with bcd_busy high throughout.
  - On completion, bcd_valid pulses high for 1 cycle and bcd_data holds the result until the next completion.
  - A new update while busy restarts the conversion; the stale result is never flagged valid.
  - Reset: bcd_data=0, bcd_valid=0, bcd_busy=0.
- Undefined: these ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package result_store_pkg holds:
  - state enum (EMPTY, LIVE, BROWSE);
  - clog2-derived width constants;
  - the saturation constant function (2^(W-1)-1).
- One sub-module, bin2bcd_seq: the iterative double-dabble engine, instantiated only under RESULT_STORE_BCD_EN.
- Sign-magnitude conversion stays inline.

Test Plan (DATA_W=16, DEPTH=4 unless noted):
1. rst held 2 cycles, then store 16'h0001 -> next cycle bin_data=16'h0001, seg_sign=0, count=1, empty=0.
2. Store 16'hFFFF, then 16'h8000 -> bin_data=1, seg_sign=1; then bin_data=16'h7FFF, seg_sign=1, sat=1.
3. Store 5, 6, 7, 8, 9 (overflow) -> count=4, full=1. recall_prev x5 -> shows 8, 7, 6, then 6 held at offset=3. recall_next x1 -> shows 7.
4. In BROWSE at offset 2, store 16'h0010 with recall_prev in the same cycle -> offset=0, bin_data=16'h0010, LIVE.
5. clear with store in the same cycle -> count=0, empty=1, bin_data=0; next recall_prev -> no change.
6. With RESULT_STORE_BCD_EN, store 16'd12345 -> bcd_busy for 16 cycles, then bcd_valid pulse with bcd_data=20'h12345. A second store at cycle 8 restarts it, and only one valid pulse follows.
